// File: rtl/regfile_rename_mp_if.sv
// Issue / CDB / operand bundle for the renaming register file.
// The master side (decode/issue plus the CDB arbiter) drives requests,
// broadcasts and control; the slave side (the register file) returns operands
// and the pending-rename count. There is no valid/ready handshake here:
// issue_valid and cdb_active are plain strobes, sampled on the rising clock
// edge while rdy_in is high.
interface regfile_rename_mp_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_CDB  = 2,
    parameter int RIDX_W   = $clog2(NUM_REGS)
);
    logic                     rdy_in;
    logic                     issue_valid;
    logic [RIDX_W-1:0]        issue_rd;
    logic [RIDX_W-1:0]        issue_rs1;
    logic [RIDX_W-1:0]        issue_rs2;
    logic [TAG_W-1:0]         issue_tag;
    logic [NUM_CDB-1:0]       cdb_active;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_val;
    logic                     flush_in;
    logic [XLEN-1:0]          vj;
    logic [XLEN-1:0]          vk;
    logic [TAG_W-1:0]         qj;
    logic [TAG_W-1:0]         qk;
    logic [RIDX_W:0]          pending_cnt;

    modport master (
        output rdy_in, issue_valid, issue_rd, issue_rs1, issue_rs2, issue_tag,
        output cdb_active, cdb_tag, cdb_val, flush_in,
        input  vj, vk, qj, qk, pending_cnt
    );

    modport slave (
        input  rdy_in, issue_valid, issue_rd, issue_rs1, issue_rs2, issue_tag,
        input  cdb_active, cdb_tag, cdb_val, flush_in,
        output vj, vk, qj, qk, pending_cnt
    );
endinterface

// File: rtl/regfile_rename_mp.sv
// Architectural register file with per-register producer tags.
// Reads resolve against the current state with same-cycle CDB bypass;
// updates retire tags from NUM_CDB broadcast channels (channel 0 wins),
// apply the issuing rename, and honour a global misprediction flush.
module regfile_rename_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_CDB  = 2,
    localparam int RIDX_W  = $clog2(NUM_REGS)
) (
    input logic              clk_in,
    input logic              rst_in,
    regfile_rename_mp_if.slave bus
);
    logic [XLEN-1:0]  val_q [NUM_REGS];
    logic [XLEN-1:0]  val_d [NUM_REGS];
    logic [TAG_W-1:0] tag_q [NUM_REGS];
    logic [TAG_W-1:0] tag_d [NUM_REGS];
    logic [RIDX_W:0]  pending_cnt_q;
    logic [RIDX_W:0]  pending_cnt_d;

    logic [XLEN-1:0]  vj_c, vk_c;
    logic [TAG_W-1:0] qj_c, qk_c;

    // Operand read: ready value, CDB bypass (lowest channel wins), or producer tag.
    always_comb begin
        vj_c = '0;
        qj_c = '0;
        vk_c = '0;
        qk_c = '0;
        if (bus.issue_valid) begin
            vj_c = val_q[bus.issue_rs1];
            qj_c = tag_q[bus.issue_rs1];
            vk_c = val_q[bus.issue_rs2];
            qk_c = tag_q[bus.issue_rs2];
            if (tag_q[bus.issue_rs1] != '0) begin
                vj_c = '0;
                for (int i = NUM_CDB - 1; i >= 0; i--) begin
                    if (bus.cdb_active[i] && bus.cdb_tag[i*TAG_W +: TAG_W] == tag_q[bus.issue_rs1]) begin
                        vj_c = bus.cdb_val[i*XLEN +: XLEN];
                        qj_c = '0;
                    end
                end
            end
            if (tag_q[bus.issue_rs2] != '0) begin
                vk_c = '0;
                for (int i = NUM_CDB - 1; i >= 0; i--) begin
                    if (bus.cdb_active[i] && bus.cdb_tag[i*TAG_W +: TAG_W] == tag_q[bus.issue_rs2]) begin
                        vk_c = bus.cdb_val[i*XLEN +: XLEN];
                        qk_c = '0;
                    end
                end
            end
        end
    end

    assign bus.vj          = vj_c;
    assign bus.vk          = vk_c;
    assign bus.qj          = qj_c;
    assign bus.qk          = qk_c;
    assign bus.pending_cnt = pending_cnt_q;

    // Next state: CDB retirement, then rename (or flush), then recount pending tags.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            val_d[r] = val_q[r];
            tag_d[r] = tag_q[r];
        end
        pending_cnt_d = '0;
        if (bus.rdy_in) begin
            // Register 0 is skipped so it stays zero with no tag.
            for (int r = 1; r < NUM_REGS; r++) begin
                for (int i = NUM_CDB - 1; i >= 0; i--) begin
                    // A zero CDB tag is treated as idle and never retires anything.
                    if (bus.cdb_active[i] && bus.cdb_tag[i*TAG_W +: TAG_W] != '0 &&
                        bus.cdb_tag[i*TAG_W +: TAG_W] == tag_q[r]) begin
                        val_d[r] = bus.cdb_val[i*XLEN +: XLEN];
                        tag_d[r] = '0;
                    end
                end
            end
            if (bus.flush_in) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    tag_d[r] = '0;
                end
            end else if (bus.issue_valid && bus.issue_rd != '0 && bus.issue_tag != '0) begin
                // The new rename overrides a same-cycle retirement of this register.
                tag_d[bus.issue_rd] = bus.issue_tag;
            end
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            if (tag_d[r] != '0) begin
                pending_cnt_d = pending_cnt_d + (RIDX_W+1)'(1);
            end
        end
    end

    // State registers; asynchronous reset discards every pending rename at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
            pending_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                val_q[r] <= val_d[r];
                tag_q[r] <= tag_d[r];
            end
            pending_cnt_q <= pending_cnt_d;
        end
    end
endmodule

// File: tb/tb_regfile_rename_mp.sv
// Directed bench for regfile_rename_mp: a table of per-cycle vectors, each
// checked half a cycle after being driven (before the edge that commits it),
// followed by a hand-written asynchronous-reset sequence.
module tb_regfile_rename_mp;
  localparam int XLEN = 32;
  localparam int TAG_W = 4;
  localparam int NUM_REGS = 32;
  localparam int NUM_CDB = 2;
  localparam int RIDX_W = 5;

  logic clk_in;
  logic rst_in;

  regfile_rename_mp_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) bus ();

  regfile_rename_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic              iv;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        act;
    logic [TAG_W-1:0]  ct1;
    logic [TAG_W-1:0]  ct0;
    logic [XLEN-1:0]   cv1;
    logic [XLEN-1:0]   cv0;
    logic              fl;
    logic              rdy;
    logic [XLEN-1:0]   evj;
    logic [TAG_W-1:0]  eqj;
    logic [XLEN-1:0]   evk;
    logic [TAG_W-1:0]  eqk;
    logic [RIDX_W:0]   ecnt;
  } vec_t;

  vec_t vecs[$];
  int n_pass;
  int n_total;

  function automatic vec_t mk(logic iv, int rd, int rs1, int rs2, int tag,
                              logic [1:0] act, int ct1, int ct0,
                              logic [XLEN-1:0] cv1, logic [XLEN-1:0] cv0,
                              logic fl, logic rdy,
                              logic [XLEN-1:0] evj, int eqj,
                              logic [XLEN-1:0] evk, int eqk, int ecnt);
    vec_t v;
    v.iv = iv; v.rd = RIDX_W'(rd); v.rs1 = RIDX_W'(rs1); v.rs2 = RIDX_W'(rs2);
    v.tag = TAG_W'(tag); v.act = act; v.ct1 = TAG_W'(ct1); v.ct0 = TAG_W'(ct0);
    v.cv1 = cv1; v.cv0 = cv0; v.fl = fl; v.rdy = rdy;
    v.evj = evj; v.eqj = TAG_W'(eqj); v.evk = evk; v.eqk = TAG_W'(eqk);
    v.ecnt = (RIDX_W+1)'(ecnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else n_pass++;
  endtask

  // driver
  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.rd;
    bus.issue_rs1   = v.rs1;
    bus.issue_rs2   = v.rs2;
    bus.issue_tag   = v.tag;
    bus.cdb_active  = v.act;
    bus.cdb_tag     = {v.ct1, v.ct0};
    bus.cdb_val     = {v.cv1, v.cv0};
    bus.flush_in    = v.fl;
    bus.rdy_in      = v.rdy;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.issue_tag = '0; bus.cdb_active = '0; bus.cdb_tag = '0; bus.cdb_val = '0;
    bus.flush_in = 1'b0; bus.rdy_in = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_in = 1'b0;
    idle();

    //            iv rd rs1 rs2 tag act    ct1 ct0 cv1           cv0           fl rdy evj           qj evk           qk cnt
    vecs.push_back(mk(0, 0, 5, 0, 0, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 0)); // reset state
    vecs.push_back(mk(1, 5, 5, 0, 3, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 0)); // rename r5->3
    vecs.push_back(mk(1, 0, 5, 5, 0, 2'b00, 0, 0, 0,            0,            0, 1, 0,            3, 0,            3, 1)); // r5 pending
    vecs.push_back(mk(1, 0, 5, 0, 0, 2'b10, 3, 0, 32'hDEADBEEF, 0,            0, 1, 32'hDEADBEEF, 0, 0,            0, 1)); // ch1 bypass
    vecs.push_back(mk(1, 0, 5, 5, 0, 2'b00, 0, 0, 0,            0,            0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0)); // retired
    vecs.push_back(mk(1, 7, 7, 0, 2, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 0)); // rename r7->2
    vecs.push_back(mk(1, 7, 7, 0, 9, 2'b01, 0, 2, 0,            32'h11,       0, 1, 32'h11,       0, 0,            0, 1)); // retire + re-rename
    vecs.push_back(mk(1, 0, 7, 0, 0, 2'b00, 0, 0, 0,            0,            0, 1, 0,            9, 0,            0, 1)); // tag9 kept
    vecs.push_back(mk(1, 3, 7, 0, 4, 2'b01, 0, 9, 0,            32'h22,       0, 1, 32'h22,       0, 0,            0, 1)); // r7 retires, r3->4
    vecs.push_back(mk(1, 0, 3, 3, 0, 2'b11, 4, 4, 32'hB,        32'hA,        0, 1, 32'hA,        0, 32'hA,        0, 1)); // ch0 priority
    vecs.push_back(mk(1, 0, 3, 7, 0, 2'b00, 0, 0, 0,            0,            0, 1, 32'hA,        0, 32'h22,       0, 0)); // r3=A, r7=0x22
    vecs.push_back(mk(1, 0, 0, 0, 6, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 0)); // rename r0 ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 0)); // r0 still clean
    vecs.push_back(mk(1, 1, 0, 0, 1, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 0)); // r1->1
    vecs.push_back(mk(1, 2, 0, 0, 2, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 1)); // r2->2
    vecs.push_back(mk(1, 4, 0, 0, 5, 2'b00, 0, 0, 0,            0,            0, 1, 0,            0, 0,            0, 2)); // r4->5
    vecs.push_back(mk(1, 8, 1, 4, 5, 2'b00, 0, 0, 0,            0,            1, 1, 0,            1, 0,            5, 3)); // flush + dropped rename
    vecs.push_back(mk(1, 1, 3, 8, 7, 2'b00, 0, 0, 0,            0,            0, 1, 32'hA,        0, 0,            0, 0)); // flushed, r1->7
    vecs.push_back(mk(1, 6, 1, 0, 3, 2'b01, 0, 7, 0,            32'h55,       0, 0, 32'h55,       0, 0,            0, 1)); // frozen, bypass live
    vecs.push_back(mk(1, 6, 1, 0, 3, 2'b01, 0, 7, 0,            32'h55,       0, 0, 32'h55,       0, 0,            0, 1)); // frozen
    vecs.push_back(mk(1, 6, 1, 0, 3, 2'b01, 0, 7, 0,            32'h55,       1, 0, 32'h55,       0, 0,            0, 1)); // frozen incl. flush
    vecs.push_back(mk(1, 0, 1, 6, 0, 2'b00, 0, 0, 0,            0,            0, 1, 0,            7, 0,            0, 1)); // nothing changed
    vecs.push_back(mk(1, 0, 1, 0, 0, 2'b11, 7, 0, 32'h77,       32'h99,       0, 1, 32'h77,       0, 0,            0, 1)); // ch0 tag 0 idle
    vecs.push_back(mk(1, 0, 1, 2, 0, 2'b00, 0, 0, 0,            0,            0, 1, 32'h77,       0, 0,            0, 0)); // r2 untouched by tag 0

    repeat (2) @(posedge clk_in);
    chk("reset_pending_cnt", XLEN'(bus.pending_cnt), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk_in);
      chk($sformatf("v%0d_vj", i), bus.vj, vecs[i].evj);
      chk($sformatf("v%0d_qj", i), XLEN'(bus.qj), XLEN'(vecs[i].eqj));
      chk($sformatf("v%0d_vk", i), bus.vk, vecs[i].evk);
      chk($sformatf("v%0d_qk", i), XLEN'(bus.qk), XLEN'(vecs[i].eqk));
      chk($sformatf("v%0d_cnt", i), XLEN'(bus.pending_cnt), XLEN'(vecs[i].ecnt));
      @(posedge clk_in);
      #1;
    end

    // Asynchronous reset in the middle of a cycle with a rename pending.
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.issue_tag = 4'd6;
    @(posedge clk_in);
    #1;
    idle();
    bus.issue_valid = 1'b1; bus.issue_rs1 = 5'd9; bus.issue_rs2 = 5'd7;
    @(negedge clk_in);
    chk("pre_rst_qj", XLEN'(bus.qj), 6);
    chk("pre_rst_cnt", XLEN'(bus.pending_cnt), 1);
    chk("pre_rst_vk", bus.vk, 32'h22);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_rst_qj", XLEN'(bus.qj), 0);
    chk("async_rst_cnt", XLEN'(bus.pending_cnt), 0);
    chk("async_rst_vk", bus.vk, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_rename_mp.md
Name: regfile_rename_mp

Overview:
- Parametrised successor to the single-CDB architectural register file with rename tags; sits between decode/issue and the reservation stations / LSB.
- Holds architectural values plus per-register producer tags.
- Supplies operand values or tags for one issuing instruction per cycle, with same-cycle CDB bypass.
- Retires tags from NUM_CDB broadcast channels, supports a global flush on misprediction, and reports the count of renamed registers.

Parameters:
- XLEN, 32, data width of registers and CDB values.
- NUM_REGS, 32, architectural register count; register 0 hard-wired to zero; power of two.
- TAG_W, 4, rename tag width; tag value 0 means None (no producer).
- NUM_CDB, 2, number of CDB broadcast channels; channel 0 has lowest index and highest priority.
- RIDX_W, $clog2(NUM_REGS), register index width (derived, not overridden).

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes all state updates.
- issue_valid  in  1  an instruction issues this cycle.
- issue_rd  in  RIDX_W  destination register.
- issue_rs1  in  RIDX_W  source 1.
- issue_rs2  in  RIDX_W  source 2.
- issue_tag  in  TAG_W  rename tag assigned to issue_rd.
- cdb_active  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  per-channel tag; channel i at [i*TAG_W +: TAG_W].
- cdb_val  in  NUM_CDB*XLEN  per-channel result value.
- flush_in  in  1  misprediction flush; clears every producer tag.
- vj  out  XLEN  source 1 value, valid when qj==0.
- vk  out  XLEN  source 2 value, valid when qk==0.
- qj  out  TAG_W  source 1 producer tag, 0 if ready.
- qk  out  TAG_W  source 2 producer tag, 0 if ready.
- pending_cnt  out  RIDX_W+1  registered count of registers with a nonzero tag.

Behaviour:
- Reset (rst_in low, async): all values <= 0; all tags <= 0; pending_cnt <= 0. Reset asserted mid-operation discards all pending renames immediately. Read outputs are combinational and read 0 when issue_valid is low.
- Register 0: value always 0, tag always 0; writes and renames to index 0 are ignored.
- Read path (combinational, issue_valid high), per source s:
  - If tag[s]==0: q=0, v=value[s].
  - Else if some channel i has cdb_active[i] and cdb_tag[i]==tag[s] (lowest i wins): q=0, v=cdb_val[i] (bypass).
  - Else: q=tag[s], v=0.
  - Reads use the pre-update state; an issue whose rs equals its own rd sees the old mapping.
- Update path (posedge, rdy_in high, flush_in low):
  - For each register r!=0 and each active channel i whose tag matches tag[r]: value[r] <= cdb_val[i] and tag[r] <= 0. If several channels match, the lowest index wins.
  - If issue_valid, issue_rd!=0 and issue_tag!=0: tag[issue_rd] <= issue_tag. This overrides a same-cycle CDB clear of that register; the CDB value is still written to value[issue_rd].
  - issue_tag==0 with issue_valid is a no-op on tags.
- Flush (flush_in high, rdy_in high): all tags <= 0, values kept. A same-cycle CDB value write still lands, but a same-cycle issue rename is dropped. The read path is unaffected during the flush cycle.
- rdy_in low: no state change; read path stays live.
- pending_cnt: after every update it equals the number of r with tag[r]!=0; it is a registered count, recomputed or tracked incrementally.
- CDB tags of 0 never match.

Test Plan:
- Reset, then issue rd=5 tag=3 -> next cycle, reading rs1=5 gives qj=3, vj=0; pending_cnt=1.
- With tag[5]=3, broadcast channel 1 tag=3 val=0xDEADBEEF while reading rs1=5 -> same cycle qj=0, vj=0xDEADBEEF; next cycle value[5]=0xDEADBEEF, tag[5]=0, pending_cnt=0.
- With tag[7]=2, in the same cycle CDB tag=2 val=0x11 and issue rd=7 tag=9 -> value[7]=0x11, tag[7]=9, pending_cnt unchanged.
- Channels 0 and 1 both broadcast tag=4, with vals 0xA and 0xB, while tag[3]=4 -> value[3]=0xA.
- Issue rd=0 tag=6, then read rs2=0 -> qk=0, vk=0, pending_cnt=0.
- Three registers renamed, then flush_in plus an issue rd=8 tag=5 -> all tags 0, tag[8]=0, pending_cnt=0, values retained. rdy_in low for 3 cycles with CDB activity -> no state change.
